// File: rtl/histo_eq_ctrl_if.sv
// rtl/histo_eq_ctrl_if.sv - image and histogram SRAM port bundle for histo_eq_ctrl
interface histo_eq_ctrl_if #(
    parameter int p_depth_bit        = 8,
    parameter int p_depth_size_bit   = 10,
    parameter int p_histo_sram_a_bit = 8,
    parameter int p_histo_sram_d_bit = 10
);
    logic                          img_rd_en;
    logic [p_depth_size_bit-1:0]   img_rd_a;
    logic [p_depth_bit-1:0]        img_rd_d;
    logic                          histo_rd_en;
    logic [p_histo_sram_a_bit-1:0] histo_rd_a;
    logic [p_histo_sram_d_bit-1:0] histo_rd_d;
    logic                          histo_wr_en;
    logic [p_histo_sram_a_bit-1:0] histo_wr_a;
    logic [p_histo_sram_d_bit-1:0] histo_wr_d;

    modport master (
        output img_rd_en, img_rd_a,
        input  img_rd_d,
        output histo_rd_en, histo_rd_a,
        input  histo_rd_d,
        output histo_wr_en, histo_wr_a, histo_wr_d
    );

    modport slave (
        input  img_rd_en, img_rd_a,
        output img_rd_d,
        input  histo_rd_en, histo_rd_a,
        output histo_rd_d,
        input  histo_wr_en, histo_wr_a, histo_wr_d
    );
endinterface

// File: rtl/histo_eq_ctrl.sv
// rtl/histo_eq_ctrl.sv - histogram build and CDF threshold sequencer; option macro HISTO_EQ_CTRL_CLEAR_ON_SCAN_EN
module histo_eq_ctrl #(
    parameter int p_depth_bit        = 8,
    parameter int p_depth_size_bit   = 10,
    parameter int p_depth_qnt_bit    = 3,
    parameter int p_th_num           = 7,
    parameter int p_histo_sram_a_bit = 8,
    parameter int p_histo_sram_d_bit = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    histo_eq_ctrl_if.master                 mem,
    output logic [p_th_num*p_depth_bit-1:0] th,
    output logic                            th_valid,
    output logic                            sat
);
    localparam int n_bins  = 2**p_depth_bit;
    localparam int n_pix   = 2**p_depth_size_bit;
    localparam int cnt_w   = p_depth_size_bit + 2;
    localparam int cdf_w   = p_depth_size_bit + 1;
    localparam int step_sh = p_depth_size_bit - p_depth_qnt_bit;
    localparam logic [p_histo_sram_d_bit-1:0] cnt_max = '1;

    typedef enum logic [2:0] {s_idle, s_clear, s_accum, s_thresh, s_done} state_t;

    state_t                        state, state_nx;
    logic [cnt_w-1:0]              cnt;
    logic                          s1_vld, s2_vld;
    logic [p_depth_bit-1:0]        s2_pix;
    logic                          prev_wr_en;
    logic [p_histo_sram_a_bit-1:0] prev_wr_a;
    logic [p_histo_sram_d_bit-1:0] prev_wr_d;
    logic [p_histo_sram_d_bit-1:0] rd_cnt, inc_val;
    logic [cdf_w-1:0]              cdf, cdf_nx;
    logic [p_th_num-1:0]           th_set;
    logic [p_depth_bit-1:0]        bin;
    logic                          thresh_data, thresh_last;
`ifdef HISTO_EQ_CTRL_CLEAR_ON_SCAN_EN
    logic                          first_frame;
`endif

    assign busy = (state != s_idle);
    assign done = (state == s_done);

    // One-deep forward: the SRAM returns old data when the previous cycle wrote the same bin
    assign rd_cnt  = (prev_wr_en && prev_wr_a == s2_pix) ? prev_wr_d : mem.histo_rd_d;
    assign inc_val = (rd_cnt == cnt_max) ? cnt_max : rd_cnt + p_histo_sram_d_bit'(1);

    assign bin         = cnt[p_depth_bit-1:0] - p_depth_bit'(1);
    assign thresh_data = (state == s_thresh) && (cnt != '0);
    assign thresh_last = (cnt == cnt_w'(n_bins));
    assign cdf_nx      = cdf + cdf_w'(mem.histo_rd_d);

    always_comb begin
        state_nx = state;
        case (state)
            s_idle: begin
                if (start) begin
`ifdef HISTO_EQ_CTRL_CLEAR_ON_SCAN_EN
                    state_nx = first_frame ? s_clear : s_accum;
`else
                    state_nx = s_clear;
`endif
                end
            end
            s_clear:  if (cnt == cnt_w'(n_bins - 1)) state_nx = s_accum;
            s_accum:  if (cnt == cnt_w'(n_pix + 1))  state_nx = s_thresh;
            s_thresh: if (thresh_last)               state_nx = s_done;
            s_done:   state_nx = s_idle;
            default:  state_nx = s_idle;
        endcase
    end

    always_comb begin
        mem.img_rd_en   = 1'b0;
        mem.img_rd_a    = '0;
        mem.histo_rd_en = 1'b0;
        mem.histo_rd_a  = '0;
        mem.histo_wr_en = 1'b0;
        mem.histo_wr_a  = '0;
        mem.histo_wr_d  = '0;
        case (state)
            s_clear: begin
                mem.histo_wr_en = 1'b1;
                mem.histo_wr_a  = cnt[p_histo_sram_a_bit-1:0];
            end
            s_accum: begin
                mem.img_rd_en   = (cnt < cnt_w'(n_pix));
                mem.img_rd_a    = cnt[p_depth_size_bit-1:0];
                mem.histo_rd_en = s1_vld;
                mem.histo_rd_a  = mem.img_rd_d;
                mem.histo_wr_en = s2_vld;
                mem.histo_wr_a  = s2_pix;
                mem.histo_wr_d  = inc_val;
            end
            s_thresh: begin
                mem.histo_rd_en = (cnt < cnt_w'(n_bins));
                mem.histo_rd_a  = cnt[p_histo_sram_a_bit-1:0];
`ifdef HISTO_EQ_CTRL_CLEAR_ON_SCAN_EN
                mem.histo_wr_en = (cnt != '0);
                mem.histo_wr_a  = bin;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= s_idle;
            cnt        <= '0;
            s1_vld     <= 1'b0;
            s2_vld     <= 1'b0;
            s2_pix     <= '0;
            prev_wr_en <= 1'b0;
            prev_wr_a  <= '0;
            prev_wr_d  <= '0;
            cdf        <= '0;
            th_set     <= '0;
            th         <= '0;
            th_valid   <= 1'b0;
            sat        <= 1'b0;
`ifdef HISTO_EQ_CTRL_CLEAR_ON_SCAN_EN
            first_frame <= 1'b1;
`endif
        end else begin
            state      <= state_nx;
            cnt        <= (state_nx != state) ? '0 : cnt + cnt_w'(1);
            s1_vld     <= mem.img_rd_en;
            s2_vld     <= s1_vld;
            s2_pix     <= mem.img_rd_d;
            prev_wr_en <= mem.histo_wr_en;
            prev_wr_a  <= mem.histo_wr_a;
            prev_wr_d  <= mem.histo_wr_d;

            if (state == s_idle && start) begin
                th_valid <= 1'b0;
                sat      <= 1'b0;
            end
            if (state == s_accum && s2_vld && rd_cnt == cnt_max)
                sat <= 1'b1;

            // All comparators look at the same running cdf, so several thresholds may land on one bin
            if (thresh_data) begin
                cdf <= cdf_nx;
                for (int k = 0; k < p_th_num; k++) begin
                    if (!th_set[k] && (cdf_nx >= cdf_w'((k + 1) << step_sh) || thresh_last)) begin
                        th[k*p_depth_bit +: p_depth_bit] <= bin;
                        th_set[k]                        <= 1'b1;
                    end
                end
            end else if (state != s_thresh) begin
                cdf    <= '0;
                th_set <= '0;
            end

            if (state == s_thresh && state_nx == s_done)
                th_valid <= 1'b1;
`ifdef HISTO_EQ_CTRL_CLEAR_ON_SCAN_EN
            if (state == s_done)
                first_frame <= 1'b0;
`endif
        end
    end
endmodule

// File: doc/histo_eq_ctrl.md
Name: histo_eq_ctrl

Overview:
- Sequences histogram build and threshold extraction for the equalizing quantizer.
- On start, the block clears the histo SRAM and streams all 2**p_depth_size_bit pixels from the image SRAM.
- It increments histo bins using read-modify-write with hazard forwarding.
- It then scans the CDF to derive p_th_num quantization thresholds, which are consumed by the quantizer stage.

Parameters:
- p_depth_bit, 8, pixel bit width
- p_depth_size_bit, 10, log2 of pixels per image
- p_depth_qnt_bit, 3, quantized pixel width; 2**p_depth_qnt_bit levels
- p_th_num, 7, number of thresholds, equal to 2**p_depth_qnt_bit-1
- p_histo_sram_a_bit, 8, histo address width, equal to p_depth_bit
- p_histo_sram_d_bit, 10, histo count width, equal to p_depth_size_bit

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  frame start pulse; ignored while busy
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at frame completion
- img_rd_en  out  1  image SRAM read enable; data returns 1 cycle later
- img_rd_a  out  p_depth_size_bit  image read address
- img_rd_d  in  p_depth_bit  image read data
- histo_rd_en  out  1  histo SRAM read enable; 1-cycle latency
- histo_rd_a  out  p_histo_sram_a_bit  histo read address
- histo_rd_d  in  p_histo_sram_d_bit  histo read data
- histo_wr_en  out  1  histo write enable
- histo_wr_a  out  p_histo_sram_a_bit  histo write address
- histo_wr_d  out  p_histo_sram_d_bit  histo write data
- th  out  p_th_num*p_depth_bit  packed thresholds; th[k] occupies bits [k*p_depth_bit +: p_depth_bit]
- th_valid  out  1  th is valid; held until the next accepted start
- sat  out  1  sticky per frame: some bin saturated

Behaviour:
- Reset:
  - All outputs are 0, FSM is in IDLE, first_frame=1.
  - Reset mid-frame aborts immediately; histo contents are then don't-care.
- Histo SRAM:
  - 1R1W; a read at the same address as a same-cycle write returns OLD data.
- FSM states: IDLE -> CLEAR -> ACCUM -> THRESH -> DONE -> IDLE.
- IDLE:
  - start=1 is accepted: busy=1 next cycle, th_valid=0, sat=0.
- CLEAR:
  - 256 cycles; writes 0 to bins 0..255 in ascending order.
- ACCUM:
  - Issues img reads at addresses 0..1023, one per cycle.
  - Stage 1: pixel p arrives; histo_rd_a=p.
  - Stage 2: count arrives; write sat_inc(count) to p, where sat_inc(x) = (x==1023) ? 1023 : x+1.
  - If saturation occurs, set sat=1.
  - Forwarding: if the stage-2 pixel equals the previous cycle's written address, use the previous written value instead of histo_rd_d. This is one-deep only, which is sufficient given the 1-cycle write.
  - Duration 1026 cycles, including pipeline drain.
- THRESH:
  - Reads bins 0..255 and accumulates cdf (p_depth_size_bit+1 bits).
  - target_k = (k+1) << (p_depth_size_bit-p_depth_qnt_bit) = 128*(k+1).
  - Each data cycle, for every k not yet set with cdf >= target_k, set th[k]=bin. All 7 comparators run in parallel, so multiple k may resolve on the same bin.
  - Any k unset after bin 255 is set to 255; this is possible only under saturation.
  - Duration 257 cycles.
- DONE:
  - One cycle: done=1, th_valid=1, busy=0 next cycle.
- Latency:
  - done is asserted 1540 cycles after the edge that samples start (1+256+1026+257).
- Thresholds are monotonic non-decreasing by construction.

Optional Feature:
- Macro: HISTO_EQ_CTRL_CLEAR_ON_SCAN_EN.
- Defined:
  - THRESH writes 0 to each bin one cycle after reading it.
  - CLEAR is executed only when first_frame=1 (after reset); first_frame is cleared at DONE.
  - Subsequent frames take 1284 cycles from start to done.
- Undefined:
  - CLEAR runs every frame, and THRESH performs no writes.

Test Plan:
- Ramp image, img[i]=i%256 (4 per bin) -> th = {31,63,95,127,159,191,223}, sat=0, done at cycle 1540.
- Constant image, all 0x55 -> bin 85 saturates at 1023, sat=1, all th=85.
- Half image 0x00, half 0xFF (back-to-back forwarding) -> histo[0]=512, histo[255]=512; th[0..3]=0, th[4..6]=255.
- Ramp frame, then constant frame; pulse start while busy -> extra start ignored; second frame results exact (proves clear). With macro, second frame done at 1284.
- rst at ACCUM cycle 500, then ramp frame -> all outputs 0 during reset, CLEAR executed, ramp thresholds exact.
